mem_access_unit: RTL and testbench

//  Memory (M) stage of the 5-stage RV32I pipeline. Sits between EX/MEM and MEM_WB.

---
 rtl/mem_access_unit.sv | 206 ++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Memory stage of the RV32I pipeline: load/store bus requests over a req/ack
// handshake, byte lanes, load extension, pipeline stall and bus timeout.
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_m,
    input  logic        mem_read_m,
    input  logic        mem_write_m,
    input  logic [2:0]  funct3_m,
    input  logic [31:0] execute_out_m,
    input  logic [31:0] store_data_m,
    input  logic        reg_write_en_m,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] dmem_readdata_m,
    output logic        reg_write_en_mw,
    output logic        stall_m,
    output logic        addr_fault_m,
    output logic        bus_error_m
);

    localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_W-1:0] CNT_LAST =
        TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        lane_q, lane_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       load_q, load_d;
    logic              berr_q, berr_d;

    logic        is_mem;
    logic [1:0]  lane;
    logic        f3_bad;
    logic        misalign;
    logic        fault_c;
    logic        mem_op;
    logic        stall_c;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic [31:0] shifted;
    logic [31:0] load_fmt;
    logic        berr_out;

    // Access decode; faults are only meaningful while a new op is presented.
    always_comb begin
        is_mem   = mem_read_m | mem_write_m;
        lane     = execute_out_m[1:0];
        f3_bad   = (funct3_m == 3'b011) | (funct3_m == 3'b110) |
                   (funct3_m == 3'b111) | (mem_write_m & funct3_m[2]);
        misalign = ((funct3_m[1:0] == 2'b01) & lane[0]) |
                   ((funct3_m[1:0] == 2'b10) & (lane != 2'b00));
        fault_c  = (state_q == S_IDLE) & valid_m & is_mem &
                   ((mem_read_m & mem_write_m) | f3_bad | misalign);
        mem_op   = valid_m & is_mem & ~fault_c;
    end

    always_comb begin
        be_c    = 4'b1111;
        wdata_c = store_data_m;
        case (funct3_m[1:0])
            2'b00: begin
                be_c    = 4'b0001 << lane;
                wdata_c = {4{store_data_m[7:0]}};
            end
            2'b01: begin
                be_c    = lane[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{store_data_m[15:0]}};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = store_data_m;
            end
        endcase
    end

    always_comb begin
        shifted  = dmem_rdata >> {lane_q, 3'b000};
        load_fmt = shifted;
        case (f3_q)
            3'b000:  load_fmt = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_fmt = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_fmt = {24'd0, shifted[7:0]};
            3'b101:  load_fmt = {16'd0, shifted[15:0]};
            default: load_fmt = shifted;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            lane_q  <= '0;
            cnt_q   <= '0;
            load_q  <= '0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            lane_q  <= lane_d;
            cnt_q   <= cnt_d;
            load_q  <= load_d;
            berr_q  <= berr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        f3_d    = f3_q;
        lane_d  = lane_q;
        cnt_d   = cnt_q;
        load_d  = load_q;
        berr_d  = berr_q;
        stall_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                stall_c = mem_op;
                if (mem_op) begin
                    state_d = S_WAIT;
                    req_d   = 1'b1;
                    we_d    = mem_write_m;
                    addr_d  = {execute_out_m[31:2], 2'b00};
                    be_d    = be_c;
                    wdata_d = wdata_c;
                    f3_d    = funct3_m;
                    lane_d  = lane;
                    cnt_d   = '0;
                    load_d  = '0;
                    berr_d  = 1'b0;
                end
            end
            S_WAIT: begin
                stall_c = 1'b1;
                cnt_d   = cnt_q + CNT_W'(1);
                // An ack arriving in the timeout cycle still completes normally.
                if (dmem_ack) begin
                    load_d  = we_q ? 32'd0 : load_fmt;
                    req_d   = 1'b0;
                    state_d = S_DONE;
                end else if (TO_EN && (cnt_q == CNT_LAST)) begin
                    load_d  = 32'd0;
                    berr_d  = 1'b1;
                    req_d   = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        berr_out        = ~reset & (state_q == S_DONE) & berr_q;
        dmem_req        = ~reset & req_q;
        dmem_we         = ~reset & we_q;
        dmem_addr       = reset ? 32'd0 : addr_q;
        dmem_be         = reset ? 4'd0 : be_q;
        dmem_wdata      = reset ? 32'd0 : wdata_q;
        dmem_readdata_m = (~reset && state_q == S_DONE) ? load_q : 32'd0;
        stall_m         = ~reset & stall_c;
        addr_fault_m    = ~reset & fault_c;
        bus_error_m     = berr_out;
        reg_write_en_mw = ~reset & reg_write_en_m & valid_m &
                          ~fault_c & ~berr_out;
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed plus randomized checks of mem_access_unit against a
// size/offset arithmetic reference model.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_m, mem_read_m, mem_write_m;
    logic [2:0]  funct3_m;
    logic [31:0] execute_out_m, store_data_m;
    logic        reg_write_en_m;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic [31:0] dmem_readdata_m;
    logic        reg_write_en_mw, stall_m, addr_fault_m, bus_error_m;

    int tests = 0;
    int fails = 0;
    int obs_stalls;
    logic [31:0] obs_out, obs_wd;
    logic [3:0]  obs_be;
    logic        obs_we, obs_berr;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .valid_m(valid_m),
        .mem_read_m(mem_read_m), .mem_write_m(mem_write_m),
        .funct3_m(funct3_m), .execute_out_m(execute_out_m),
        .store_data_m(store_data_m), .reg_write_en_m(reg_write_en_m),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .dmem_readdata_m(dmem_readdata_m),
        .reg_write_en_mw(reg_write_en_mw), .stall_m(stall_m),
        .addr_fault_m(addr_fault_m), .bus_error_m(bus_error_m)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit m_fault(input bit rd, input bit wr, input logic [2:0] f3,
                                   input logic [31:0] addr);
        int sz;
        if (!(rd || wr)) return 1'b0;
        if (rd && wr) return 1'b1;
        if (f3 == 3 || f3 == 6 || f3 == 7) return 1'b1;
        if (wr && f3 > 2) return 1'b1;
        sz = 1 << (f3 % 4);
        return (addr % sz) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] addr);
        int sz;
        sz = 1 << (f3 % 4);
        return 4'(((1 << sz) - 1) << (addr % 4));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
        int sz;
        sz = 1 << (f3 % 4);
        if (sz == 1) return (d % 256) * 32'h01010101;
        if (sz == 2) return (d % 65536) * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] rd);
        longint unsigned v, md, sz;
        sz = 64'd1 << (f3 % 4);
        v = longint'(rd) / (64'd1 << (8 * (addr % 4)));
        if (sz == 4) return v[31:0];
        md = 64'd1 << (8 * sz);
        v = v % md;
        if (f3 < 4 && v >= md / 2) v = v + 64'h1_0000_0000 - md;
        return v[31:0];
    endfunction

    // ackd: WAIT cycle (1-based) in which ack is driven; 0 = never ack
    task automatic run_op(input bit rd, input bit wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] sd,
                          input logic [31:0] rdat, input bit rwe, input int ackd);
        bit flt, berr;
        int k, exp_st;
        logic [31:0] exp_out;
        flt = m_fault(rd, wr, f3, addr);
        valid_m = 1'b1; mem_read_m = rd; mem_write_m = wr; funct3_m = f3;
        execute_out_m = addr; store_data_m = sd; reg_write_en_m = rwe;
        dmem_ack = 1'b0;
        #1;
        check("addr_fault", addr_fault_m, flt);
        if (flt || !(rd || wr)) begin
            check("stall_noop", stall_m, 0);
            check("rwe_noop", reg_write_en_mw, rwe & !flt);
            check("rdata_noop", dmem_readdata_m, 0);
            @(posedge clk); #1;
            check("req_noop", dmem_req, 0);
            check("stall_noop2", stall_m, 0);
            valid_m = 1'b0;
            obs_stalls = 0;
            return;
        end
        k = 0;
        while (stall_m === 1'b1 && k < 40) begin
            if (k >= 1) begin
                check("req_wait", dmem_req, 1);
                check("we_wait", dmem_we, wr);
                check("addr_wait", dmem_addr, addr - (addr % 4));
                check("be_wait", dmem_be, m_be(f3, addr));
                check("wdata_wait", dmem_wdata, m_wdata(f3, sd));
                obs_be = dmem_be; obs_wd = dmem_wdata; obs_we = dmem_we;
                if (k == ackd) begin
                    dmem_ack = 1'b1;
                    dmem_rdata = rdat;
                end
            end
            @(posedge clk); #1;
            dmem_ack = 1'b0;
            dmem_rdata = $urandom;
            k++;
        end
        check("stall_bound", (k < 40), 1);
        berr = !(ackd >= 1 && ackd <= 16);
        exp_st = berr ? 17 : 1 + ackd;
        exp_out = (berr || wr) ? 32'd0 : m_load(f3, addr, rdat);
        obs_stalls = k;
        obs_out = dmem_readdata_m;
        obs_berr = bus_error_m;
        check("stall_cycles", k, exp_st);
        check("done_out", dmem_readdata_m, exp_out);
        check("done_berr", bus_error_m, berr);
        check("done_rwe", reg_write_en_mw, rwe & !berr);
        check("done_req", dmem_req, 0);
        @(posedge clk); #1;
        valid_m = 1'b0; mem_read_m = 1'b0; mem_write_m = 1'b0;
        #1;
        check("idle_out", dmem_readdata_m, 0);
        check("idle_berr", bus_error_m, 0);
        check("idle_stall", stall_m, 0);
    endtask

    initial begin
        reset = 1'b1; valid_m = 1'b0; mem_read_m = 1'b0; mem_write_m = 1'b0;
        funct3_m = 3'd0; execute_out_m = 32'd0; store_data_m = 32'd0;
        reg_write_en_m = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'd0;
        #1;
        check("rst_req0", dmem_req, 0);
        check("rst_stall0", stall_m, 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", dmem_req, 0);
        check("rst_we", dmem_we, 0);
        check("rst_addr", dmem_addr, 0);
        check("rst_be", dmem_be, 0);
        check("rst_wdata", dmem_wdata, 0);
        check("rst_out", dmem_readdata_m, 0);
        check("rst_berr", bus_error_m, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // LW aligned, ack in first WAIT cycle
        run_op(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1, 1);
        check("lw_stalls", obs_stalls, 2);
        check("lw_out", obs_out, 32'hDEADBEEF);
        check("lw_be", obs_be, 4'b1111);

        run_op(1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 1, 1);
        check("lb_be", obs_be, 4'b1000);
        check("lb_out", obs_out, 32'hFFFFFF80);
        run_op(1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF_0000, 1, 2);
        check("lbu_out", obs_out, 32'h00000080);

        run_op(0, 1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0, 0, 3);
        check("sh_be", obs_be, 4'b1100);
        check("sh_wdata", obs_wd, 32'hABCDABCD);
        check("sh_we", obs_we, 1);
        check("sh_stalls", obs_stalls, 4);

        run_op(1, 0, 3'b010, 32'h101, 32'h0, 32'h0, 1, 1);

        // No ack: timeout after 16 WAIT cycles
        run_op(1, 0, 3'b010, 32'h200, 32'h0, 32'h0, 1, 0);
        check("to_berr", obs_berr, 1);
        check("to_out", obs_out, 0);
        check("to_stalls", obs_stalls, 17);

        // Ack in the timeout cycle completes normally
        run_op(1, 0, 3'b010, 32'h204, 32'h0, 32'h0BAD_F00D, 1, 16);
        check("ack16_berr", obs_berr, 0);
        check("ack16_out", obs_out, 32'h0BAD_F00D);

        // Reset in second WAIT cycle; a later ack is ignored
        valid_m = 1'b1; mem_read_m = 1'b1; mem_write_m = 1'b0;
        funct3_m = 3'b010; execute_out_m = 32'h300; reg_write_en_m = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rw_req", dmem_req, 1);
        reset = 1'b1;
        #1;
        check("rw_req_rst", dmem_req, 0);
        check("rw_stall_rst", stall_m, 0);
        @(posedge clk); #1;
        reset = 1'b0; valid_m = 1'b0; mem_read_m = 1'b0;
        #1;
        check("rw_req_after", dmem_req, 0);
        check("rw_stall_after", stall_m, 0);
        dmem_ack = 1'b1; dmem_rdata = 32'h5555AAAA;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        #1;
        check("late_ack_out", dmem_readdata_m, 0);
        check("late_ack_berr", bus_error_m, 0);
        check("late_ack_req", dmem_req, 0);
        check("late_ack_stall", stall_m, 0);
        @(posedge clk); #1;
        check("late_ack_out2", dmem_readdata_m, 0);

        for (int i = 0; i < 80; i++) begin
            int r, ad;
            bit rd, wr;
            logic [2:0] f3;
            logic [31:0] a;
            r = $urandom_range(0, 9);
            rd = (r == 1) || (r >= 2 && r <= 5);
            wr = (r == 1) || (r >= 6);
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 4) != 0) begin
                a = $urandom;
                if (wr) f3 = 3'(a % 3);
                else if (f3 == 3 || f3 >= 6) f3 = 3'b100;
            end
            a = $urandom;
            if ($urandom_range(0, 1) == 0) a = a & ~(32'h3 >> (f3 == 0 ? 2 : 0));
            ad = ($urandom_range(0, 11) == 0) ? 0 : $urandom_range(1, 5);
            run_op(rd, wr, f3, a, $urandom, $urandom, 1'($urandom_range(0, 1)), ad);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
